// File: rtl/param_memory.sv
// param_memory: single-port word memory with a valid/ready request port,
// per-byte write enables and a registered one-cycle response.
// After reset, or when clear is requested, a sweep zeroes one word per cycle.
// Because of that sweep the array needs no reset and can map to block RAM.
// Optional feature: define MEMORY_PARITY_EN to store one even-parity bit per
// byte and flag mismatches on read responses.
module param_memory #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BE_WIDTH-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  parity_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_addr, clr_addr_nxt;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   merged_word;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef MEMORY_PARITY_EN
  logic [BE_WIDTH-1:0]     mem_par [DEPTH];
  logic [BE_WIDTH-1:0]     rd_par;
  logic                    par_bad;
`endif

  // State register and sweep address pointer.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // Next-state logic and handshake outputs.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    busy         = 1'b0;
    req_ready    = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        busy         = 1'b1;
        clr_addr_nxt = clr_addr + ADDR_WIDTH'(1);
        if (clr_addr == '1) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        // clear wins over any request presented in the same cycle
        req_ready = !clear;
        if (clear) begin
          state_nxt    = ST_CLEAR;
          clr_addr_nxt = '0;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  assign accept = req_valid && req_ready;

  // Current word at the request address and its byte-merged write image.
  always_comb begin
    rd_word     = mem[req_addr];
    merged_word = rd_word;
    for (int k = 0; k < BE_WIDTH; k++) begin
      if (req_be[k]) merged_word[k*8 +: 8] = req_wdata[k*8 +: 8];
    end
  end

`ifdef MEMORY_PARITY_EN
  // Recompute even parity of the stored bytes and compare with stored bits.
  always_comb begin
    rd_par  = mem_par[req_addr];
    par_bad = 1'b0;
    for (int k = 0; k < BE_WIDTH; k++) begin
      if ((^rd_word[k*8 +: 8]) != rd_par[k]) par_bad = 1'b1;
    end
  end
`endif

  // Array write port: sweep zeroing while clearing, byte writes when idle.
  // NOTE: the array is deliberately not reset; the clear sweep initialises
  // it, which keeps it mappable onto block RAM.
  always_ff @(posedge clock) begin
    if (state == ST_CLEAR) begin
      mem[clr_addr] <= '0;
`ifdef MEMORY_PARITY_EN
      mem_par[clr_addr] <= '0;
`endif
    end else if (accept && req_write) begin
      for (int k = 0; k < BE_WIDTH; k++) begin
        if (req_be[k]) begin
          mem[req_addr][k*8 +: 8] <= req_wdata[k*8 +: 8];
`ifdef MEMORY_PARITY_EN
          mem_par[req_addr][k] <= ^req_wdata[k*8 +: 8];
`endif
        end
      end
    end
  end

  // Registered response: one pulse per accepted request, data held otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept;
      if (accept) rsp_rdata <= req_write ? merged_word : rd_word;
    end
  end

`ifdef MEMORY_PARITY_EN
  // Parity error is reported only on read responses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) parity_err <= 1'b0;
    else          parity_err <= accept && !req_write && par_bad;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
